// File: rtl/sfifo_pkg.sv
// Shared helpers for sfifo_cnt: count-width function and parameter legality check.
package sfifo_pkg;

    function automatic int CNT_BW(input int n);
        return $clog2(n + 1);
    endfunction

    // 1 when depth and both thresholds fall in their legal ranges.
    function automatic bit params_ok(input int ndata, input int afull_th, input int aempty_th);
        return (ndata >= 2) &&
               (afull_th >= 1) && (afull_th <= ndata) &&
               (aempty_th >= 0) && (aempty_th <= ndata - 1);
    endfunction

endpackage

// File: rtl/sfifo_wrap_ptr.sv
// Modulo-N pointer (0..N-1) with increment, synchronous clear and async active-low reset.
module sfifo_wrap_ptr #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          inc,
    input  logic          clr,
    output logic [PW-1:0] ptr
);

    localparam logic [PW-1:0] LAST = PW'(N - 1);

    // Wrap by explicit compare so non-power-of-two depths never skip or overrun.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            ptr <= '0;
        else if (clr)
            ptr <= '0;
        else if (inc)
            ptr <= (ptr == LAST) ? '0 : ptr + PW'(1);
    end

endmodule

// File: rtl/sfifo_cnt.sv
// Register-based synchronous FIFO with occupancy count, almost-full/empty flags and flush.
// Optional zero-latency fall-through when empty: define SFIFO_BYPASS_EN.
module sfifo_cnt
    import sfifo_pkg::*;
#(
    parameter int BW        = 8,
    parameter int NDATA     = 4,
    parameter int AFULL_TH  = 3,
    parameter int AEMPTY_TH = 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        src_rdy,
    output logic                        src_ack,
    input  logic [BW-1:0]               i_data,
    output logic                        dst_rdy,
    input  logic                        dst_ack,
    output logic [BW-1:0]               o_data,
    input  logic                        i_flush,
    output logic [CNT_BW(NDATA)-1:0]    o_cnt,
    output logic                        o_afull,
    output logic                        o_aempty
);

    localparam int CW = CNT_BW(NDATA);
    localparam int AW = (NDATA > 1) ? $clog2(NDATA) : 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(NDATA);
    localparam logic [CW-1:0] AF_TH    = CW'(AFULL_TH);
    localparam logic [CW-1:0] AE_TH    = CW'(AEMPTY_TH);

    generate
        if (!params_ok(NDATA, AFULL_TH, AEMPTY_TH)) begin : g_bad_param
            initial begin
                $error("%m: illegal parameters NDATA=%0d AFULL_TH=%0d AEMPTY_TH=%0d",
                       NDATA, AFULL_TH, AEMPTY_TH);
                $finish;
            end
        end
    endgenerate

    logic [NDATA-1:0][BW-1:0] mem;
    logic [AW-1:0]            ra, wa;
    logic [CW-1:0]            cnt, cnt_nxt;
    logic                     full, empty;
    logic                     push, pop;

    assign full  = (cnt == FULL_CNT);
    assign empty = (cnt == '0);

    // A full FIFO refuses writes even if a read happens in the same cycle.
    assign src_ack = src_rdy & ~full & ~i_flush;

`ifdef SFIFO_BYPASS_EN
    logic byp;
    assign byp     = empty & ~i_flush;
    assign dst_rdy = byp ? src_rdy : (~empty & ~i_flush);
    assign o_data  = byp ? i_data : mem[ra];
    // A word consumed straight through never lands in storage.
    assign push    = src_ack & ~(byp & dst_ack);
    assign pop     = dst_ack & ~empty & ~i_flush;
`else
    assign dst_rdy = ~empty & ~i_flush;
    assign o_data  = mem[ra];
    assign push    = src_ack;
    assign pop     = dst_ack & dst_rdy;
`endif

    always_comb begin
        cnt_nxt = cnt;
        if (i_flush)
            cnt_nxt = '0;
        else if (push && !pop)
            cnt_nxt = cnt + CW'(1);
        else if (pop && !push)
            cnt_nxt = cnt - CW'(1);
    end

    sfifo_wrap_ptr #(.N(NDATA), .PW(AW)) u_wa (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .inc   (push),
        .clr   (i_flush),
        .ptr   (wa)
    );

    sfifo_wrap_ptr #(.N(NDATA), .PW(AW)) u_ra (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .inc   (pop),
        .clr   (i_flush),
        .ptr   (ra)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            mem <= '0;
        else if (push)
            mem[wa] <= i_data;
    end

    // Flags track the next-state count so they line up with o_cnt.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt      <= '0;
            o_afull  <= 1'b0;
            o_aempty <= 1'b1;
        end else begin
            cnt      <= cnt_nxt;
            o_afull  <= (cnt_nxt >= AF_TH);
            o_aempty <= (cnt_nxt <= AE_TH);
        end
    end

    assign o_cnt = cnt;

endmodule

// File: tb/tb_sfifo_cnt.sv
// Directed bench for sfifo_cnt: depth-4 instance for fill/drain/flush/reset, depth-5 for wrap.
module tb_sfifo_cnt;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       sr4 = 1'b0, da4 = 1'b0, fl4 = 1'b0;
    logic [7:0] d4  = '0;
    logic       sa4, dr4, af4, ae4;
    logic [7:0] od4;
    logic [2:0] cnt4;

    logic       sr5 = 1'b0, da5 = 1'b0, fl5 = 1'b0;
    logic [7:0] d5  = '0;
    logic       sa5, dr5, af5, ae5;
    logic [7:0] od5;
    logic [2:0] cnt5;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] q4[$];
    logic [7:0] q5[$];

    always #5 clk = ~clk;

    sfifo_cnt #(.BW(8), .NDATA(4), .AFULL_TH(3), .AEMPTY_TH(1)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .src_rdy(sr4), .src_ack(sa4), .i_data(d4),
        .dst_rdy(dr4), .dst_ack(da4), .o_data(od4), .i_flush(fl4),
        .o_cnt(cnt4), .o_afull(af4), .o_aempty(ae4)
    );

    sfifo_cnt #(.BW(8), .NDATA(5), .AFULL_TH(4), .AEMPTY_TH(1)) u_dut5 (
        .i_clk(clk), .i_rst(rst), .src_rdy(sr5), .src_ack(sa5), .i_data(d5),
        .dst_rdy(dr5), .dst_ack(da5), .o_data(od5), .i_flush(fl5),
        .o_cnt(cnt5), .o_afull(af5), .o_aempty(ae5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock on the depth-4 FIFO with inputs already driven; scoreboard + state checks.
    task automatic cyc4();
        logic [7:0] e;
        #1;
        if (sa4) q4.push_back(d4);
        if (da4) begin
            if (q4.size() == 0) chk("pop_underflow", 32'd1, 32'd0);
            else begin
                e = q4.pop_front();
                chk("pop_data", od4, e);
            end
        end
        @(posedge clk); #1;
        if (fl4) q4.delete();
        chk("cnt", cnt4, q4.size());
        chk("afull", af4, q4.size() >= 3);
        chk("aempty", ae4, q4.size() <= 1);
    endtask

    task automatic idle4();
        sr4 = 1'b0; da4 = 1'b0; fl4 = 1'b0;
    endtask

    initial begin
        int got;
        int sent;
        int cycles;
        logic [7:0] e;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cnt", cnt4, 0);
        chk("rst_dst_rdy", dr4, 0);
        chk("rst_afull", af4, 0);
        chk("rst_aempty", ae4, 1);
        chk("rst_odata", od4, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Fill to full
        for (int i = 0; i < 4; i++) begin
            sr4 = 1'b1; d4 = 8'(8'h11 * (i + 1)); da4 = 1'b0;
            #1 chk("fill_ack", sa4, 1);
            cyc4();
        end
        sr4 = 1'b1; d4 = 8'h55; da4 = 1'b0;
        #1 chk("full_no_ack", sa4, 0);
        cyc4();
        // Full with a read in the same cycle still refuses the write
        sr4 = 1'b1; d4 = 8'h66; da4 = 1'b1;
        #1 chk("full_rd_no_ack", sa4, 0);
        cyc4();
        // Drain
        sr4 = 1'b0;
        while (q4.size() != 0) begin
            da4 = 1'b1;
            cyc4();
        end
        da4 = 1'b0;
        #1 chk("drained_dst_rdy", dr4, 0);

        // Simultaneous push/pop at cnt=2
        sr4 = 1'b1; d4 = 8'hA0; cyc4();
        d4 = 8'hA1; cyc4();
        for (int i = 0; i < 10; i++) begin
            sr4 = 1'b1; da4 = 1'b1; d4 = 8'(8'hB0 + i);
            cyc4();
        end
        chk("pushpop_cnt", cnt4, 2);
        sr4 = 1'b0;
        while (q4.size() != 0) begin da4 = 1'b1; cyc4(); end
        idle4();

        // Flush at cnt=3 with a concurrent push attempt
        for (int i = 0; i < 3; i++) begin sr4 = 1'b1; d4 = 8'(8'hC0 + i); cyc4(); end
        sr4 = 1'b1; d4 = 8'hCF; fl4 = 1'b1; da4 = 1'b0;
        #1;
        chk("flush_src_ack", sa4, 0);
        chk("flush_dst_rdy", dr4, 0);
        cyc4();
        chk("post_flush_cnt", cnt4, 0);
        chk("post_flush_aempty", ae4, 1);
        fl4 = 1'b0; sr4 = 1'b1; d4 = 8'hA5;
        cyc4();
        sr4 = 1'b0;
        #1;
        chk("post_flush_rdy", dr4, 1);
        chk("post_flush_data", od4, 8'hA5);
        da4 = 1'b1; cyc4();
        idle4();

        // Async reset mid-stream at cnt=2
        sr4 = 1'b1; d4 = 8'hD1; cyc4();
        d4 = 8'hD2; cyc4();
        idle4();
        #1 rst = 1'b0;
        #1;
        chk("async_rst_cnt", cnt4, 0);
        chk("async_rst_dst_rdy", dr4, 0);
        q4.delete();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        sr4 = 1'b1; d4 = 8'h3C; cyc4();
        sr4 = 1'b0; da4 = 1'b1; cyc4();
        idle4();

        // Wrap on depth 5: 23 words with random stalls
        sent = 0; got = 0; cycles = 0;
        while ((sent < 23 || q5.size() != 0) && cycles < 1000) begin
            sr5 = (sent < 23);
            d5  = 8'(sent * 7 + 3);
            da5 = 1'b0;
            #1;
            da5 = dr5 & ($urandom_range(0, 2) != 0);
            #1;
            if (sa5) begin q5.push_back(d5); sent++; end
            if (da5) begin
                if (q5.size() == 0) chk("wrap_underflow", 32'd1, 32'd0);
                else begin
                    e = q5.pop_front();
                    chk("wrap_data", od5, e);
                    got++;
                end
            end
            @(posedge clk); #1;
            chk("wrap_cnt", cnt5, q5.size());
            cycles++;
        end
        sr5 = 1'b0; da5 = 1'b0;
        chk("wrap_received", got, 23);

        // Empty-FIFO latency
`ifdef SFIFO_BYPASS_EN
        sr4 = 1'b1; d4 = 8'h5A; da4 = 1'b1;
        #1;
        chk("byp_dst_rdy", dr4, 1);
        chk("byp_odata", od4, 8'h5A);
        chk("byp_src_ack", sa4, 1);
        cyc4();
        chk("byp_cnt", cnt4, 0);
`else
        sr4 = 1'b1; d4 = 8'h5A; da4 = 1'b0;
        #1;
        chk("lat_src_ack", sa4, 1);
        chk("lat_dst_rdy_same", dr4, 0);
        cyc4();
        sr4 = 1'b0;
        #1;
        chk("lat_dst_rdy_next", dr4, 1);
        chk("lat_odata", od4, 8'h5A);
        da4 = 1'b1; cyc4();
`endif
        idle4();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
